// File: rtl/ssemi_csr_burst_initiator_pkg.sv
// Shared types and constants for the decimator CSR burst initiator.
// Optional write-verify support is built when SSEMI_CSR_WR_VERIFY_EN is defined.
package ssemi_csr_pkg;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_CSR_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int CMD_LEN_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_ISSUE = 3'd2,
    ST_VERIFY   = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_OUT   = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Decimator CSR address map
  localparam logic [7:0] CSR_CTRL       = 8'h00;
  localparam logic [7:0] CSR_STATUS     = 8'h04;
  localparam logic [7:0] CSR_DECIM_RATE = 8'h08;
  localparam logic [7:0] CSR_GAIN       = 8'h0C;
  localparam logic [7:0] CSR_COEF_BASE  = 8'h10;

endpackage

// File: rtl/ssemi_csr_burst_initiator_if.sv
// Command, data-stream and CSR bus signals of the burst initiator.
// o_verify_err exists only when SSEMI_CSR_WR_VERIFY_EN is defined.
interface ssemi_csr_burst_initiator_if #(
  parameter int ADDR_WIDTH     = 8,
  parameter int CSR_DATA_WIDTH = 32
) ();

  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic                      i_cmd_write;
  logic [ADDR_WIDTH-1:0]     i_cmd_addr;
  logic [7:0]                i_cmd_len;
  logic                      i_wdata_valid;
  logic [CSR_DATA_WIDTH-1:0] i_wdata;
  logic                      o_wdata_ready;
  logic                      o_rdata_valid;
  logic [CSR_DATA_WIDTH-1:0] o_rdata;
  logic                      i_rdata_ready;
  logic                      o_csr_wr_valid;
  logic [ADDR_WIDTH-1:0]     o_csr_addr;
  logic [CSR_DATA_WIDTH-1:0] o_csr_wr_data;
  logic                      i_csr_wr_ready;
  logic                      o_csr_rd_ready;
  logic [CSR_DATA_WIDTH-1:0] i_csr_rd_data;
  logic                      o_done;
  logic                      o_timeout;
  logic                      o_busy;
`ifdef SSEMI_CSR_WR_VERIFY_EN
  logic                      o_verify_err;
`endif

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    input  i_wdata_valid, i_wdata, i_rdata_ready,
    input  i_csr_wr_ready, i_csr_rd_data,
    output o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata,
    output o_csr_wr_valid, o_csr_addr, o_csr_wr_data, o_csr_rd_ready,
`ifdef SSEMI_CSR_WR_VERIFY_EN
    output o_verify_err,
`endif
    output o_done, o_timeout, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    output i_wdata_valid, i_wdata, i_rdata_ready,
    output i_csr_wr_ready, i_csr_rd_data,
    input  o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata,
    input  o_csr_wr_valid, o_csr_addr, o_csr_wr_data, o_csr_rd_ready,
`ifdef SSEMI_CSR_WR_VERIFY_EN
    input  o_verify_err,
`endif
    input  o_done, o_timeout, o_busy
  );

endinterface

// File: rtl/ssemi_csr_burst_initiator_timeout_cnt.sv
// Per-beat write-accept timeout counter: clear/enable with expiry flag.
// Unaffected by SSEMI_CSR_WR_VERIFY_EN.
module ssemi_csr_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_reg;

  // Saturates at the expiry value so a stalled enable cannot wrap it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else if (i_clear) begin
      count_reg <= '0;
    end else if (i_enable && !o_expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/ssemi_csr_burst_initiator.sv
// Burst CSR initiator: issues up to 256 consecutive CSR writes/reads per command.
// Define SSEMI_CSR_WR_VERIFY_EN to add a read-back verify after every write beat.
module ssemi_csr_burst_initiator
  import ssemi_csr_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CSR_DATA_WIDTH = DEF_CSR_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  ssemi_csr_burst_initiator_if.master bus
);

  state_e                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [7:0]                len_reg;
  logic [7:0]                beat_reg;
  logic [CSR_DATA_WIDTH-1:0] data_reg;
  logic [CSR_DATA_WIDTH-1:0] rdata_reg;
  logic                      timeout_reg;

  logic cmd_accept, wdata_accept, beat_advance, rd_capture;
  logic timeout_fire, tmo_enable, tmo_expired, last_beat;
`ifdef SSEMI_CSR_WR_VERIFY_EN
  logic verify_check;
  logic verify_err_reg;
`endif

  assign last_beat = (beat_reg == len_reg);

  ssemi_csr_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (wdata_accept),
    .i_enable  (tmo_enable),
    .o_expired (tmo_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cmd_accept   = 1'b0;
    wdata_accept = 1'b0;
    beat_advance = 1'b0;
    rd_capture   = 1'b0;
    timeout_fire = 1'b0;
    tmo_enable   = 1'b0;
`ifdef SSEMI_CSR_WR_VERIFY_EN
    verify_check = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          cmd_accept = 1'b1;
          state_next = bus.i_cmd_write ? ST_WR_DATA : ST_RD_ISSUE;
        end
      end
      ST_WR_DATA: begin
        if (bus.i_wdata_valid) begin
          wdata_accept = 1'b1;
          state_next   = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        if (bus.i_csr_wr_ready) begin
`ifdef SSEMI_CSR_WR_VERIFY_EN
          state_next = ST_VERIFY;
`else
          beat_advance = !last_beat;
          state_next   = last_beat ? ST_DONE : ST_WR_DATA;
`endif
        end else if (tmo_expired) begin
          // Abort: remaining write beats are left in the host stream.
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          tmo_enable = 1'b1;
        end
      end
`ifdef SSEMI_CSR_WR_VERIFY_EN
      ST_VERIFY: begin
        verify_check = 1'b1;
        beat_advance = !last_beat;
        state_next   = last_beat ? ST_DONE : ST_WR_DATA;
      end
`endif
      ST_RD_ISSUE: begin
        rd_capture = 1'b1;
        state_next = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (bus.i_rdata_ready) begin
          beat_advance = !last_beat;
          state_next   = last_beat ? ST_DONE : ST_RD_ISSUE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_reg    <= '0;
      len_reg     <= '0;
      beat_reg    <= '0;
      data_reg    <= '0;
      rdata_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_fire;
      if (cmd_accept) begin
        addr_reg <= bus.i_cmd_addr;
        len_reg  <= bus.i_cmd_len;
        beat_reg <= '0;
      end else if (beat_advance) begin
        addr_reg <= addr_reg + 1'b1;
        beat_reg <= beat_reg + 1'b1;
      end
      if (wdata_accept) data_reg  <= bus.i_wdata;
      if (rd_capture)   rdata_reg <= bus.i_csr_rd_data;
    end
  end

`ifdef SSEMI_CSR_WR_VERIFY_EN
  // Sticky until the next command is accepted; mismatches never stop the burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      verify_err_reg <= 1'b0;
    end else if (cmd_accept) begin
      verify_err_reg <= 1'b0;
    end else if (verify_check && (bus.i_csr_rd_data != data_reg)) begin
      verify_err_reg <= 1'b1;
    end
  end
  assign bus.o_verify_err   = verify_err_reg;
  assign bus.o_csr_rd_ready = (state_reg == ST_RD_ISSUE) || (state_reg == ST_VERIFY);
`else
  assign bus.o_csr_rd_ready = (state_reg == ST_RD_ISSUE);
`endif

  assign bus.o_cmd_ready    = (state_reg == ST_IDLE);
  assign bus.o_busy         = (state_reg != ST_IDLE);
  assign bus.o_wdata_ready  = (state_reg == ST_WR_DATA);
  assign bus.o_csr_wr_valid = (state_reg == ST_WR_ISSUE);
  assign bus.o_csr_addr     = addr_reg;
  assign bus.o_csr_wr_data  = data_reg;
  assign bus.o_rdata_valid  = (state_reg == ST_RD_OUT);
  assign bus.o_rdata        = rdata_reg;
  assign bus.o_done         = (state_reg == ST_DONE);
  assign bus.o_timeout      = timeout_reg;

endmodule

// File: doc/ssemi_csr_burst_initiator.md
Name: ssemi_csr_burst_initiator

Overview:
- CSR initiator (master) for the decimator's shared-address CSR write/read interface.
- Accepts burst commands: up to 256 consecutive register accesses from a start address.
- Writes take data from an input stream; reads return data on an output stream.
- Sits between the host/firmware bridge and the decimator CSR port; adds a per-beat write-accept timeout with abort.

Parameters:
- ADDR_WIDTH, 8, CSR address width.
- CSR_DATA_WIDTH, 32, CSR data width.
- TIMEOUT_CYCLES, 64, max cycles o_csr_wr_valid may wait for i_csr_wr_ready (2-65535).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted (IDLE only).
- i_cmd_write  in  1  1=write burst, 0=read burst.
- i_cmd_addr  in  ADDR_WIDTH  start address.
- i_cmd_len  in  8  beats minus one.
- i_wdata_valid  in  1  write-data stream valid.
- i_wdata  in  CSR_DATA_WIDTH  write data.
- o_wdata_ready  out  1  write-data stream ready.
- o_rdata_valid  out  1  read-data stream valid.
- o_rdata  out  CSR_DATA_WIDTH  read data.
- i_rdata_ready  in  1  read-data stream ready.
- o_csr_wr_valid  out  1  CSR write valid.
- o_csr_addr  out  ADDR_WIDTH  CSR address, shared by read and write.
- o_csr_wr_data  out  CSR_DATA_WIDTH  CSR write data.
- i_csr_wr_ready  in  1  CSR write ready.
- o_csr_rd_ready  out  1  CSR read strobe.
- i_csr_rd_data  in  CSR_DATA_WIDTH  read data, valid in the same cycle as o_csr_rd_ready.
- o_done  out  1  one-cycle burst-complete pulse.
- o_timeout  out  1  one-cycle pulse on aborted burst.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0 except o_cmd_ready=1. State IDLE, beat counter 0, timeout counter 0.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, latch addr, len and rw.
  - Go to WR_DATA (write) or RD_ISSUE (read).
- WR_DATA:
  - o_wdata_ready=1.
  - On i_wdata_valid, latch data, clear timeout counter, go to WR_ISSUE.
  - No timeout while waiting for data.
- WR_ISSUE:
  - o_csr_wr_valid=1; o_csr_addr and o_csr_wr_data held stable.
  - On i_csr_wr_ready, beat completes. Last beat goes to DONE; otherwise increment address and go to WR_DATA.
  - Timeout counter increments each cycle without ready. On reaching TIMEOUT_CYCLES-1 without ready: pulse o_timeout, drop o_csr_wr_valid, go to IDLE.
  - On abort, remaining write beats are not consumed; the host flushes its stream.
- RD_ISSUE:
  - o_csr_rd_ready=1 for exactly one cycle with o_csr_addr driven.
  - i_csr_rd_data captured into o_rdata that cycle; go to RD_OUT.
- RD_OUT:
  - o_rdata_valid=1; o_rdata held until i_rdata_ready.
  - Then: last beat goes to DONE; otherwise increment address and go to RD_ISSUE.
  - No timeout on read backpressure.
- DONE: o_done=1 for one cycle, then IDLE.
- Per-beat cost: 2 cycles minimum for writes (ready tied high), 2 cycles for reads (ready tied high). Command-to-first-CSR-strobe latency: 1 cycle for reads, 2 for writes.
- Address increments modulo 2^ADDR_WIDTH: 0xFF+1 wraps to 0x00, no error.
- i_cmd_len=0 is a single beat; i_cmd_len=255 is 256 beats.
- o_csr_wr_valid and o_csr_rd_ready are never high together.
- Commands presented while busy are ignored (not accepted).
- Asynchronous reset mid-burst returns to IDLE immediately; the partial burst is lost and no o_done is issued.

Optional Feature:
- Macro SSEMI_CSR_WR_VERIFY_EN.
- When defined:
  - After each accepted write, add a VERIFY state: one-cycle o_csr_rd_ready at the same address, comparing i_csr_rd_data to the written data.
  - On mismatch, set sticky output o_verify_err (1 bit, reset 0, cleared on next command acceptance) and continue the burst.
  - Adds 1 cycle per write beat.
- When undefined: no VERIFY state and no o_verify_err port.

Decomposition:
- Package ssemi_csr_pkg holds:
  - state encoding localparams (IDLE, WR_DATA, WR_ISSUE, VERIFY, RD_ISSUE, RD_OUT, DONE);
  - default ADDR_WIDTH / CSR_DATA_WIDTH / TIMEOUT_CYCLES constants;
  - decimator CSR address map constants.
- One sub-module: ssemi_csr_timeout_cnt (clear/enable counter with expiry flag).

Test Plan:
- Write burst, addr=0x10, len=3, data 0xA0..0xA3, csr_wr_ready tied 1 -> four writes to 0x10..0x13 with matching data, o_done pulses once, o_cmd_ready back high.
- Read burst, addr=0x20, len=1, i_csr_rd_data = addr-derived (0x1000+addr), i_rdata_ready stalled 3 cycles on beat 0 -> o_rdata 0x1020 held stable through the stall, then 0x1021; one o_csr_rd_ready pulse per beat.
- Wrap: write addr=0xFE, len=2 -> CSR addresses 0xFE, 0xFF, 0x00; o_done pulses.
- Timeout: TIMEOUT_CYCLES=8, i_csr_wr_ready held 0 -> o_csr_wr_valid drops after 8 cycles, o_timeout pulses, no o_done, state IDLE.
- Reset mid-burst: assert i_rst_n=0 during beat 2 of a len=5 read -> all outputs at reset values immediately; a new command after release runs normally.
- With SSEMI_CSR_WR_VERIFY_EN: write 0x5A5A to addr 0x04, readback returns 0x5A5B -> o_verify_err=1; cleared on the next command acceptance.
